bin_pixel_front: RTL and testbench

- Upstream feeder for the centroid/window tracker stage.
- Converts a raw RGB565 video stream (vs/de/pixel) into the binary-pixel interface that stage consumes: 1-bit data, de, and 10-bit x/y coordinates.
- Also produces a one-cycle end-of-frame pulse and the final coordinates of the previous frame, so the downstream stage can close its accumulation.
- Pipelined luma computation, threshold compare and coordinate generation; all outputs are registered and aligned.

---
 rtl/bin_pixel_front.sv | 178 +++++++++++++++++
 tb/tb_bin_pixel_front.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bin_pixel_front.sv
// rtl/bin_pixel_front.sv - RGB565 stream to binary pixels with x/y coordinates and end-of-frame summary
module bin_pixel_front #(
  parameter logic       INVERT = 1'b0,
  parameter logic [9:0] X_MAX  = 10'd1023,
  parameter logic [9:0] Y_MAX  = 10'd1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vs_in,
  input  logic        de_in,
  input  logic [15:0] rgb_in,
  input  logic [7:0]  thresh,
  output logic        data_out,
  output logic        de_out,
  output logic [9:0]  x_out,
  output logic [9:0]  y_out,
  output logic        eof,
  output logic [9:0]  last_x,
  output logic [9:0]  last_y
);

  // front-end state: sync/enable history, counters, frame bookkeeping
  logic       vs_d_q, de_d_q;
  logic [9:0] x_cnt_q, x_cnt_d;
  logic [9:0] y_cnt_q, y_cnt_d;
  logic       first_q, first_d;
  logic [7:0] thresh_lat_q, thresh_lat_d;
  logic [9:0] trk_x_q, trk_x_d, trk_y_q, trk_y_d;
  logic [9:0] snap_x_q, snap_x_d, snap_y_q, snap_y_d;

  // stage 1
  logic        s1_de_q, s1_eof_q;
  logic [9:0]  s1_x_q, s1_y_q;
  logic [15:0] s1_pr_q, s1_pg_q, s1_pb_q;

  // stage 2 / outputs
  logic       data_q, de_q, eof_q;
  logic [9:0] x_q, y_q, last_x_q, last_y_q;

  logic        vs_rise, de_fall;
  logic [9:0]  x_base, y_base;
  logic [7:0]  r8, g8, b8;
  logic [15:0] prod_r, prod_g, prod_b;
  logic [17:0] sum;
  logic        ge, hit;

  // edge detection, counter next-state and frame bookkeeping
  always_comb begin
    vs_rise = vs_in & ~vs_d_q;
    de_fall = de_d_q & ~de_in;
    // a frame start clears the counters before the pixel in the same cycle uses them
    x_base  = vs_rise ? 10'd0 : x_cnt_q;
    y_base  = vs_rise ? 10'd0 : y_cnt_q;

    x_cnt_d = x_base;
    if (de_in) begin
      x_cnt_d = (x_base >= X_MAX) ? X_MAX : x_base + 10'd1;
    end else if (de_fall) begin
      x_cnt_d = 10'd0;
    end

    y_cnt_d = y_base;
    if (de_fall && !vs_rise) begin
      y_cnt_d = (y_cnt_q >= Y_MAX) ? Y_MAX : y_cnt_q + 10'd1;
    end

    first_d      = vs_rise ? 1'b0 : first_q;
    thresh_lat_d = vs_rise ? thresh : thresh_lat_q;

    // tracker restarts each frame so an empty frame reports 0,0
    trk_x_d = vs_rise ? 10'd0 : (de_in ? x_cnt_q : trk_x_q);
    trk_y_d = vs_rise ? 10'd0 : (de_in ? y_cnt_q : trk_y_q);

    // previous frame's last pixel, held until eof reaches the output stage
    snap_x_d = vs_rise ? trk_x_q : snap_x_q;
    snap_y_d = vs_rise ? trk_y_q : snap_y_q;
  end

  // channel expansion and weighted luma products
  always_comb begin
    r8     = {rgb_in[15:11], rgb_in[15:13]};
    g8     = {rgb_in[10:5], rgb_in[10:9]};
    b8     = {rgb_in[4:0], rgb_in[4:2]};
    prod_r = 16'd77  * {8'd0, r8};
    prod_g = 16'd150 * {8'd0, g8};
    prod_b = 16'd29  * {8'd0, b8};
  end

  // luma sum and threshold decision; sum never exceeds 65280, so
  // sum[15:8] >= t is the same test as sum >= t*256
  always_comb begin
    sum = {2'b00, s1_pr_q} + {2'b00, s1_pg_q} + {2'b00, s1_pb_q};
    ge  = (sum >= {2'b00, thresh_lat_q, 8'h00});
    hit = INVERT ? ~ge : ge;
  end

  // front-end registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d_q       <= 1'b0;
      de_d_q       <= 1'b0;
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      first_q      <= 1'b1;
      thresh_lat_q <= 8'd128;
      trk_x_q      <= '0;
      trk_y_q      <= '0;
      snap_x_q     <= '0;
      snap_y_q     <= '0;
    end else begin
      vs_d_q       <= vs_in;
      de_d_q       <= de_in;
      x_cnt_q      <= x_cnt_d;
      y_cnt_q      <= y_cnt_d;
      first_q      <= first_d;
      thresh_lat_q <= thresh_lat_d;
      trk_x_q      <= trk_x_d;
      trk_y_q      <= trk_y_d;
      snap_x_q     <= snap_x_d;
      snap_y_q     <= snap_y_d;
    end
  end

  // stage 1: products plus delayed enable, eof request and coordinates
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_de_q  <= 1'b0;
      s1_eof_q <= 1'b0;
      s1_x_q   <= '0;
      s1_y_q   <= '0;
      s1_pr_q  <= '0;
      s1_pg_q  <= '0;
      s1_pb_q  <= '0;
    end else begin
      s1_de_q  <= de_in;
      s1_eof_q <= vs_rise & ~first_q;
      if (de_in) begin
        s1_x_q <= x_base;
        s1_y_q <= y_base;
      end
      s1_pr_q  <= prod_r;
      s1_pg_q  <= prod_g;
      s1_pb_q  <= prod_b;
    end
  end

  // stage 2: registered outputs, binary pixel gated by enable
  always_ff @(posedge clk) begin
    if (rst) begin
      de_q     <= 1'b0;
      data_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      eof_q    <= 1'b0;
      last_x_q <= '0;
      last_y_q <= '0;
    end else begin
      de_q   <= s1_de_q;
      data_q <= s1_de_q & hit;
      x_q    <= s1_x_q;
      y_q    <= s1_y_q;
      eof_q  <= s1_eof_q;
      if (s1_eof_q) begin
        last_x_q <= snap_x_q;
        last_y_q <= snap_y_q;
      end
    end
  end

  assign data_out = data_q;
  assign de_out   = de_q;
  assign x_out    = x_q;
  assign y_out    = y_q;
  assign eof      = eof_q;
  assign last_x   = last_x_q;
  assign last_y   = last_y_q;

endmodule

// File: tb/tb_bin_pixel_front.sv
// tb/tb_bin_pixel_front.sv - directed checks for bin_pixel_front
module tb_bin_pixel_front;

  logic        clk = 1'b0;
  logic        rst, vs_in, de_in;
  logic [15:0] rgb_in;
  logic [7:0]  thresh;

  logic       d_data, d_de, d_eof;
  logic [9:0] d_x, d_y, d_lx, d_ly;
  logic       i_data, i_de, i_eof;
  logic [9:0] i_x, i_y, i_lx, i_ly;
  logic       s_data, s_de, s_eof;
  logic [9:0] s_x, s_y, s_lx, s_ly;

  int checks = 0;
  int errors = 0;

  logic       pend_chk = 1'b0;
  logic       p_de, p_d, p_ee;
  logic [9:0] p_x, p_y;
  logic [9:0] hx = '0, hy = '0;
  int         g;
  logic [15:0] pat [4] = '{16'hFFFF, 16'h07E0, 16'hFFE0, 16'h0000};
  logic [3:0]  pat_e = 4'b0101;

  always #5 clk = ~clk;

  bin_pixel_front u_dut (
    .clk(clk), .rst(rst), .vs_in(vs_in), .de_in(de_in), .rgb_in(rgb_in), .thresh(thresh),
    .data_out(d_data), .de_out(d_de), .x_out(d_x), .y_out(d_y), .eof(d_eof),
    .last_x(d_lx), .last_y(d_ly)
  );

  bin_pixel_front #(.INVERT(1'b1)) u_inv (
    .clk(clk), .rst(rst), .vs_in(vs_in), .de_in(de_in), .rgb_in(rgb_in), .thresh(thresh),
    .data_out(i_data), .de_out(i_de), .x_out(i_x), .y_out(i_y), .eof(i_eof),
    .last_x(i_lx), .last_y(i_ly)
  );

  bin_pixel_front #(.X_MAX(10'd5)) u_sat (
    .clk(clk), .rst(rst), .vs_in(vs_in), .de_in(de_in), .rgb_in(rgb_in), .thresh(thresh),
    .data_out(s_data), .de_out(s_de), .x_out(s_x), .y_out(s_y), .eof(s_eof),
    .last_x(s_lx), .last_y(s_ly)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one clock of stimulus; outputs of the previous step's pixel are checked
  task automatic tick(input logic vs, input logic de, input logic [15:0] rgb,
                      input logic ed, input logic [9:0] ex, input logic [9:0] ey,
                      input logic ee);
    vs_in  = vs;
    de_in  = de;
    rgb_in = rgb;
    @(posedge clk);
    #1;
    if (pend_chk) begin
      chk1("de_out", d_de, p_de);
      chk1("data_out", d_data, p_de & p_d);
      chk10("x_out", d_x, p_x);
      chk10("y_out", d_y, p_y);
      chk1("eof", d_eof, p_ee);
      chk1("inv_data_out", i_data, p_de & ~p_d);
      chk10("sat_x_out", s_x, (p_x > 10'd5) ? 10'd5 : p_x);
    end
    if (de) begin
      hx = ex;
      hy = ey;
    end
    pend_chk = 1'b1;
    p_de = de;
    p_d  = ed;
    p_x  = hx;
    p_y  = hy;
    p_ee = ee;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk1("rst_data_out", d_data, 1'b0);
    chk1("rst_de_out", d_de, 1'b0);
    chk10("rst_x_out", d_x, 10'd0);
    chk10("rst_y_out", d_y, 10'd0);
    chk1("rst_eof", d_eof, 1'b0);
    chk10("rst_last_x", d_lx, 10'd0);
    chk10("rst_last_y", d_ly, 10'd0);
    chk1("rst_inv_data_out", i_data, 1'b0);
    chk10("rst_sat_x_out", s_x, 10'd0);
    rst = 1'b0;
    pend_chk = 1'b0;
    hx = '0;
    hy = '0;
  endtask

  initial begin
    rst    = 1'b1;
    vs_in  = 1'b0;
    de_in  = 1'b0;
    rgb_in = 16'h0000;
    thresh = 8'd0;
    do_reset();

    // default threshold 128: white -> 1, black -> 0
    tick(1'b0, 1'b1, 16'hFFFF, 1'b1, 10'd0, 10'd0, 1'b0);
    tick(1'b0, 1'b1, 16'h0000, 1'b0, 10'd1, 10'd0, 1'b0);
    tick(1'b0, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b0);

    // first frame: threshold 100, green ramp, threshold changed mid-frame
    thresh = 8'd100;
    tick(1'b1, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b0);
    for (int ln = 0; ln < 3; ln++) begin
      if (ln == 1) thresh = 8'd200;
      for (int px = 0; px < 8; px++) begin
        g = ((ln * 8 + px) * 63) / 23;
        tick(1'b0, 1'b1, {5'd0, g[5:0], 5'd0}, (g >= 43), 10'(px), 10'(ln), 1'b0);
      end
      tick(1'b0, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b0);
      tick(1'b0, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b0);
    end

    // second frame: eof with previous frame's last pixel, threshold now 200
    tick(1'b1, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b1);
    tick(1'b0, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b0);
    chk10("last_x_frame1", d_lx, 10'd7);
    chk10("last_y_frame1", d_ly, 10'd2);
    for (int ln = 0; ln < 3; ln++) begin
      for (int px = 0; px < 4; px++) begin
        tick(1'b0, 1'b1, pat[px], pat_e[px], 10'(px), 10'(ln), 1'b0);
      end
      tick(1'b0, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b0);
      tick(1'b0, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b0);
    end

    // third frame starts with a pixel in the vs_rise cycle
    tick(1'b1, 1'b1, 16'hFFFF, 1'b1, 10'd0, 10'd0, 1'b1);
    tick(1'b0, 1'b1, 16'h07E0, 1'b0, 10'd1, 10'd0, 1'b0);
    chk10("last_x_frame2", d_lx, 10'd3);
    chk10("last_y_frame2", d_ly, 10'd2);
    tick(1'b0, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b0);

    // fourth frame is empty
    tick(1'b1, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b1);
    tick(1'b0, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b0);
    chk10("last_x_frame3", d_lx, 10'd1);
    chk10("last_y_frame3", d_ly, 10'd0);
    tick(1'b0, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b0);
    tick(1'b1, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b1);
    tick(1'b0, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b0);
    chk10("last_x_empty", d_lx, 10'd0);
    chk10("last_y_empty", d_ly, 10'd0);

    // nine-pixel line: the X_MAX=5 instance saturates
    for (int px = 0; px < 9; px++) begin
      tick(1'b0, 1'b1, 16'hFFFF, 1'b1, 10'(px), 10'd0, 1'b0);
    end
    tick(1'b0, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b0);

    // reset in the middle of a line, then a frame start without eof
    tick(1'b0, 1'b1, 16'hFFFF, 1'b1, 10'd0, 10'd1, 1'b0);
    tick(1'b0, 1'b1, 16'hFFFF, 1'b1, 10'd1, 10'd1, 1'b0);
    do_reset();
    tick(1'b1, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b0);
    tick(1'b0, 1'b1, 16'hFFFF, 1'b1, 10'd0, 10'd0, 1'b0);
    tick(1'b0, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b0);
    tick(1'b0, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b0);
    chk10("last_x_after_rst", d_lx, 10'd0);
    chk1("eof_after_rst", d_eof, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
